// File: rtl/niossoc_pio_in_edge.sv
// rtl/niossoc_pio_in_edge.sv - Avalon-MM input PIO with synchronizer, edge capture and level IRQ
//
// Purpose:
//   Samples WIDTH asynchronous input pins through a SYNC_STAGES-deep
//   synchronizer, exposes the synchronized value as the data register,
//   latches per-bit edges into edgecapture and raises a level irq when any
//   captured edge is enabled in interruptmask.
//
// Register map (address):
//   0 data          read: synchronized inputs, writes ignored
//   1 reserved      reads 0, writes ignored
//   2 interruptmask read/write, WIDTH bits
//   3 edgecapture   read; write clears bits (see PIO_IN_EDGE_BITCLR_EN)
//
// Optional feature macro: PIO_IN_EDGE_BITCLR_EN
//   defined   : write to edgecapture clears only the bits set in writedata
//   undefined : any write to edgecapture clears every bit
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   address[1:0]        register select
//   chipselect, write_n slave select, active-low write strobe
//   writedata[31:0]     write data (bits above WIDTH ignored)
//   readdata[31:0]      registered read data, one cycle latency
//   in_port[WIDTH-1:0]  asynchronous external inputs
//   irq                 level interrupt request

module niossoc_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_INIT = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [CW-1:0]    prime_cnt;

  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             mask_wr;
  logic             ec_wr;
  logic             unused_wdata;

  // Upper writedata bits are intentionally ignored.
  assign unused_wdata = ^writedata;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign mask_wr  = chipselect && !write_n && (address == 2'd2);
  assign ec_wr    = chipselect && !write_n && (address == 2'd3);

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = sync_out & ~prev;
      1:       edge_raw = ~sync_out & prev;
      default: edge_raw = sync_out ^ prev;
    endcase
  end

  // Until the synchronizer and prev have been refilled after reset, a pin
  // already high would look like a fresh edge; hold edge detect off.
  assign edge_det = (prime_cnt == '0) ? edge_raw : '0;

  always_comb begin
    clr = '0;
    if (ec_wr) begin
`ifdef PIO_IN_EDGE_BITCLR_EN
      clr = writedata[WIDTH-1:0];
`else
      clr = '1;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_out;
      2'd2:    rd_mux[WIDTH-1:0] = mask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev      <= '0;
      mask      <= '0;
      edgecap   <= '0;
      readdata  <= '0;
      prime_cnt <= PRIME_INIT;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_out;
      if (prime_cnt != '0) prime_cnt <= prime_cnt - 1'b1;
      if (mask_wr) mask <= writedata[WIDTH-1:0];
      // Set wins over clear so an edge coinciding with a clear is kept.
      edgecap  <= edge_det | (edgecap & ~clr);
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & mask);

endmodule

// File: tb/tb_niossoc_pio_in_edge.sv
// tb/tb_niossoc_pio_in_edge.sv - self-checking bench for niossoc_pio_in_edge

module tb_niossoc_pio_in_edge;

  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int ET    = 0;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  niossoc_pio_in_edge #(.WIDTH(WIDTH), .SYNC_STAGES(S), .EDGE_TYPE(ET)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: sync_out is the input sampled S-1 edges ago (zero if
  // fewer samples exist since reset); edges are ignored for the first S+1
  // edges after reset.
  logic [7:0]  hist[$];
  logic [7:0]  m_sync, m_prev, m_mask, m_ec;
  logic [31:0] m_rd;
  int          ncyc;

  always @(posedge clk) begin
    logic [7:0] old_sync, old_prev, e, clr;
    if (reset) begin
      hist.delete();
      m_sync = 0; m_prev = 0; m_mask = 0; m_ec = 0; m_rd = 0; ncyc = 0;
    end else begin
      old_sync = m_sync;
      old_prev = m_prev;
      if (ET == 0)      e = old_sync & ~old_prev;
      else if (ET == 1) e = ~old_sync & old_prev;
      else              e = old_sync ^ old_prev;
      if (ncyc < S + 1) e = 0;
      case (address)
        2'd0:    m_rd = {24'h0, old_sync};
        2'd2:    m_rd = {24'h0, m_mask};
        2'd3:    m_rd = {24'h0, m_ec};
        default: m_rd = 32'h0;
      endcase
      clr = 0;
      if (chipselect && !write_n && address == 2'd3) begin
`ifdef PIO_IN_EDGE_BITCLR_EN
        clr = writedata[7:0];
`else
        clr = 8'hFF;
`endif
      end
      m_ec = e | (m_ec & ~clr);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
      hist.push_back(in_port);
      m_sync = (hist.size() >= S) ? hist[hist.size() - S] : 8'h00;
      m_prev = old_sync;
      ncyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'h0, irq}, {31'h0, |(m_ec & m_mask)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic rd_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    tick();
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  initial begin
    logic [31:0] clr_res;
    reset = 1; in_port = 8'hFF; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    tick();
    chk_en = 1;
    tick(); tick();
    @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick();
    reset = 0;
    repeat (6) tick();
    rd_expect(2'd0, 32'hFF, "data_ff_after_reset");
    check("prime_irq", {31'h0, irq}, 32'h0);
    rd_expect(2'd3, 32'h0, "prime_no_edge");

    // Rising edge on bit 0 with mask bit 0.
    in_port = 8'h00;
    repeat (4) tick();
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h01);
    address = 2'd3;
    in_port = 8'h01;
    tick(); tick();
    @(negedge clk);
    check("irq_n1", {31'h0, irq}, 32'h0);
    tick();
    @(negedge clk);
    check("irq_n2", {31'h0, irq}, 32'h1);
    tick();
    @(negedge clk);
    check("rd_ec_bit0", readdata, 32'h1);

    // Masked edge on bit 3, then unmask.
    wr(2'd2, 32'h00);
    wr(2'd3, 32'hFF);
    in_port = 8'h09;
    repeat (4) tick();
    rd_expect(2'd3, 32'h08, "ec_bit3_masked");
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h08);
    @(negedge clk);
    check("irq_after_mask", {31'h0, irq}, 32'h1);

    // Clear behaviour with edgecapture = 0C.
    wr(2'd2, 32'h00);
    in_port = 8'h00;
    repeat (4) tick();
    wr(2'd3, 32'hFF);
    in_port = 8'h0C;
    repeat (4) tick();
    rd_expect(2'd3, 32'h0C, "ec_0c");
`ifdef PIO_IN_EDGE_BITCLR_EN
    wr(2'd3, 32'h04);
    clr_res = 32'h08;
`else
    wr(2'd3, 32'h00);
    clr_res = 32'h00;
`endif
    rd_expect(2'd3, clr_res, "ec_after_clear");

    // Clear coinciding with detection of a rising edge on bit 0.
    wr(2'd2, 32'h01);
    wr(2'd3, 32'hFF);
    in_port = 8'h0D;
    tick(); tick();
    address = 2'd3; writedata = 32'h1; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1; writedata = 0;
    @(negedge clk);
    check("setwins_irq", {31'h0, irq}, 32'h1);
    tick();
    @(negedge clk);
    check("setwins_ec", readdata, 32'h1);

    // Writes to read-only/reserved addresses.
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'hFFFFFFFF);
    rd_expect(2'd1, 32'h0, "addr1_reads_zero");
    in_port = 8'hA5;
    repeat (3) tick();
    rd_expect(2'd0, 32'hA5, "data_tracks");

    // Randomized traffic including occasional mid-run resets.
    repeat (3000) begin
      reset      = ($urandom_range(0, 199) == 0);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
    end
    reset = 0; chipselect = 0; write_n = 1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/niossoc_pio_in_edge.md
Name: niossoc_pio_in_edge

Overview:
- Avalon-MM slave input PIO: the read-side counterpart to the SoC's write-only output PIOs.
- Samples WIDTH external input pins through a synchronizer and exposes them on the data register.
- Captures edges per bit in an edgecapture register.
- Raises a level IRQ to the Nios II when any captured edge is enabled in the interruptmask register. Sits on the system interconnect next to the output PIOs.

Parameters:
WIDTH, 8, number of input pins (1..32)
SYNC_STAGES, 2, synchronizer flops per bit (2..4)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  2  register select: 0 data, 1 reserved, 2 interruptmask, 3 edgecapture
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; bits above WIDTH ignored
readdata  output  32  registered read data; bits above WIDTH always 0
in_port  input  WIDTH  asynchronous external inputs
irq  output  1  level interrupt request

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - sync chain, prev, data, mask, edgecapture, readdata all 0; irq 0.
  - prime counter loaded with SYNC_STAGES+1.
- Synchronizer: in_port -> SYNC_STAGES flops; sync_out = last stage.
- prev <= sync_out every cycle.
- Edge detect, combinational:
  - rise = sync_out & ~prev
  - fall = ~sync_out & prev
  - any = rise | fall; selected by EDGE_TYPE.
- Prime guard:
  - Counter decrements each cycle after reset until 0.
  - While nonzero, edge detect is forced to 0. This suppresses false edges from pins already high at reset.
- Latency, in_port change sampled at edge N (steady state):
  - sync_out valid after edge N+SYNC_STAGES-1.
  - edgecapture bit set at edge N+SYNC_STAGES.
  - irq high in the same cycle as the edgecapture bit.
- data register: readable copy of sync_out. Writes to address 0 are ignored.
- Address 1: reads 0, writes ignored.
- interruptmask (addr 2):
  - Write (chipselect && !write_n) loads writedata[WIDTH-1:0].
  - Readable.
- edgecapture (addr 3):
  - Per bit: edgecapture[i] <= edge[i] | (edgecapture[i] & ~clr[i]).
  - Clear mechanism is set by PIO_IN_EDGE_BITCLR_EN (below).
  - Simultaneous edge and clear on the same bit: set wins, so the edge is never lost.
- irq = |(edgecapture & mask), registered-source combinational, no extra delay.
- readdata:
  - Registered every cycle from the address mux, independent of chipselect.
  - Read latency 1 cycle.
  - Upper bits (above WIDTH) zero.
- Reset mid-operation: all state returns to reset values on the next clk edge. The prime counter restarts.
- Writes never stall. There is no waitrequest.

Optional Feature:
- Macro: PIO_IN_EDGE_BITCLR_EN
- Defined: write to addr 3 clears only bits set in writedata (write-1-to-clear); clr = writedata[WIDTH-1:0].
- Undefined: any write to addr 3 clears all edgecapture bits regardless of writedata; clr = all ones.
- Set-wins rule applies in both builds.

Test Plan:
- Reset with in_port=8'hFF held through and after reset:
  - data reads 8'hFF once sync settles.
  - edgecapture stays 8'h00.
  - irq stays 0 (prime guard).
- EDGE_TYPE=0, mask=8'h01, in_port 0->8'h01 at edge N:
  - edgecapture=8'h01 and irq=1 at edge N+2.
  - readdata at addr 3 returns 32'h1 one cycle after address is presented.
- mask=8'h00 with edge on bit 3:
  - edgecapture=8'h08, irq=0.
  - Writing mask=8'h08 raises irq the cycle after the write.
- BITCLR build, edgecapture=8'h0C, write 8'h04 to addr 3 -> edgecapture=8'h08.
- Non-BITCLR build, edgecapture=8'h0C, write 32'h0 to addr 3 -> edgecapture=8'h00.
- Clear write on bit 0 in the same cycle its rising edge is detected -> bit 0 remains 1, irq stays asserted.
- Writes to addr 0 and addr 1 with 32'hFFFFFFFF:
  - data still tracks in_port.
  - addr 1 reads 32'h0.
  - readdata[31:WIDTH] always 0.
